// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a small accumulator-bus CPU (fetch + ldi/jal/jr/add/halt).
// Latency: every state lasts one clk; outputs are registered alongside the state register.
// Backpressure: none; the sequence free-runs until HALT, and only clr restarts it.
module control_sequencer (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   output logic        pc_out,
   output logic        pc_increment,
   output logic        pc_enable,
   output logic        mar_enable,
   output logic        read,
   output logic        mdr_enable,
   output logic        mdr_out,
   output logic        ir_enable,
   output logic        y_enable,
   output logic        z_enable,
   output logic        zlo_out,
   output logic        c_sign_extended_out,
   output logic        gra,
   output logic        grb,
   output logic        grc,
   output logic        r_in,
   output logic        r_out,
   output logic        ba_out,
   output logic        r8_enable,
   output logic        run,
   output logic [4:0]  state
);

   typedef enum logic [4:0] {
      S_RST  = 5'd0,
      S_T0   = 5'd1,
      S_T1   = 5'd2,
      S_T2   = 5'd3,
      S_LDI3 = 5'd4,
      S_LDI4 = 5'd5,
      S_LDI5 = 5'd6,
      S_JAL3 = 5'd7,
      S_JAL4 = 5'd8,
      S_JR3  = 5'd9,
      S_ADD3 = 5'd10,
      S_ADD4 = 5'd11,
      S_ADD5 = 5'd12,
      S_HALT = 5'd13
   } state_t;

   typedef struct packed {
      logic pc_out;
      logic pc_increment;
      logic pc_enable;
      logic mar_enable;
      logic read;
      logic mdr_enable;
      logic mdr_out;
      logic ir_enable;
      logic y_enable;
      logic z_enable;
      logic zlo_out;
      logic c_sign_extended_out;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic ba_out;
      logic r8_enable;
   } ctrl_t;

   localparam logic [4:0] OP_LDI  = 5'b01001;
   localparam logic [4:0] OP_JAL  = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   run_q, run_d;

   logic [4:0] opcode;
   logic       unused_ir_bits;

   assign opcode         = ir[31:27];
   assign unused_ir_bits = ^ir[26:0];

   // Control word for a given state; anything not listed stays 0.
   function automatic ctrl_t decode(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_T0: begin
            c.pc_out       = 1'b1;
            c.mar_enable   = 1'b1;
            c.pc_increment = 1'b1;
            c.z_enable     = 1'b1;
         end
         S_T1: begin
            c.read       = 1'b1;
            c.mdr_enable = 1'b1;
            c.zlo_out    = 1'b1;
            c.pc_enable  = 1'b1;
         end
         S_T2: begin
            c.mdr_out   = 1'b1;
            c.ir_enable = 1'b1;
         end
         S_LDI3: begin
            c.grb      = 1'b1;
            c.ba_out   = 1'b1;
            c.y_enable = 1'b1;
         end
         S_LDI4: begin
            c.c_sign_extended_out = 1'b1;
            c.z_enable            = 1'b1;
         end
         S_LDI5, S_ADD5: begin
            c.zlo_out = 1'b1;
            c.gra     = 1'b1;
            c.r_in    = 1'b1;
         end
         S_JAL3: begin
            c.pc_out    = 1'b1;
            c.r8_enable = 1'b1;
         end
         S_JAL4, S_JR3: begin
            c.gra       = 1'b1;
            c.r_out     = 1'b1;
            c.pc_enable = 1'b1;
         end
         S_ADD3: begin
            c.grb      = 1'b1;
            c.r_out    = 1'b1;
            c.y_enable = 1'b1;
         end
         S_ADD4: begin
            c.grc      = 1'b1;
            c.r_out    = 1'b1;
            c.z_enable = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Next-state logic; dispatch samples the opcode on the edge that leaves T2,
   // so ir must already hold the fetched instruction at that edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:  state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2: begin
            case (opcode)
               OP_LDI:  state_d = S_LDI3;
               OP_JAL:  state_d = S_JAL3;
               OP_JR:   state_d = S_JR3;
               OP_ADD:  state_d = S_ADD3;
               OP_HALT: state_d = S_HALT;
               default: state_d = S_T0;
            endcase
         end
         S_LDI3: state_d = S_LDI4;
         S_LDI4: state_d = S_LDI5;
         S_LDI5: state_d = S_T0;
         S_JAL3: state_d = S_JAL4;
         S_JAL4: state_d = S_T0;
         S_JR3:  state_d = S_T0;
         S_ADD3: state_d = S_ADD4;
         S_ADD4: state_d = S_ADD5;
         S_ADD5: state_d = S_T0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
      ctrl_d = decode(state_d);
      run_d  = (state_d != S_RST) && (state_d != S_HALT);
   end

   // State and its decoded control word are registered together, so the
   // outputs are glitch-free and always match the visible state.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_RST;
         ctrl_q  <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         run_q   <= run_d;
      end
   end

   assign pc_out              = ctrl_q.pc_out;
   assign pc_increment        = ctrl_q.pc_increment;
   assign pc_enable           = ctrl_q.pc_enable;
   assign mar_enable          = ctrl_q.mar_enable;
   assign read                = ctrl_q.read;
   assign mdr_enable          = ctrl_q.mdr_enable;
   assign mdr_out             = ctrl_q.mdr_out;
   assign ir_enable           = ctrl_q.ir_enable;
   assign y_enable            = ctrl_q.y_enable;
   assign z_enable            = ctrl_q.z_enable;
   assign zlo_out             = ctrl_q.zlo_out;
   assign c_sign_extended_out = ctrl_q.c_sign_extended_out;
   assign gra                 = ctrl_q.gra;
   assign grb                 = ctrl_q.grb;
   assign grc                 = ctrl_q.grc;
   assign r_in                = ctrl_q.r_in;
   assign r_out               = ctrl_q.r_out;
   assign ba_out              = ctrl_q.ba_out;
   assign r8_enable           = ctrl_q.r8_enable;
   assign run                 = run_q;
   assign state               = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level model of state sequences and per-state controls.
// Latency: checks every cycle, sampled 1 time unit after the rising edge.
// Backpressure: none; stimulus is ir and clr only.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] ir;
   logic pc_out, pc_increment, pc_enable, mar_enable, read, mdr_enable, mdr_out;
   logic ir_enable, y_enable, z_enable, zlo_out, c_sign_extended_out;
   logic gra, grb, grc, r_in, r_out, ba_out, r8_enable, run;
   logic [4:0] state;

   control_sequencer dut (
      .clk(clk), .clr(clr), .ir(ir),
      .pc_out(pc_out), .pc_increment(pc_increment), .pc_enable(pc_enable),
      .mar_enable(mar_enable), .read(read), .mdr_enable(mdr_enable),
      .mdr_out(mdr_out), .ir_enable(ir_enable), .y_enable(y_enable),
      .z_enable(z_enable), .zlo_out(zlo_out),
      .c_sign_extended_out(c_sign_extended_out),
      .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
      .ba_out(ba_out), .r8_enable(r8_enable), .run(run), .state(state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   wire [18:0] obs_sig = {pc_out, pc_increment, pc_enable, mar_enable, read,
                          mdr_enable, mdr_out, ir_enable, y_enable, z_enable,
                          zlo_out, c_sign_extended_out, gra, grb, grc, r_in,
                          r_out, ba_out, r8_enable};
   wire [5:0]  drivers = {pc_out, mdr_out, zlo_out, c_sign_extended_out, r_out, ba_out};

   localparam logic [18:0] M_PC_OUT  = 19'd1 << 18;
   localparam logic [18:0] M_PC_INC  = 19'd1 << 17;
   localparam logic [18:0] M_PC_EN   = 19'd1 << 16;
   localparam logic [18:0] M_MAR_EN  = 19'd1 << 15;
   localparam logic [18:0] M_READ    = 19'd1 << 14;
   localparam logic [18:0] M_MDR_EN  = 19'd1 << 13;
   localparam logic [18:0] M_MDR_OUT = 19'd1 << 12;
   localparam logic [18:0] M_IR_EN   = 19'd1 << 11;
   localparam logic [18:0] M_Y_EN    = 19'd1 << 10;
   localparam logic [18:0] M_Z_EN    = 19'd1 << 9;
   localparam logic [18:0] M_ZLO     = 19'd1 << 8;
   localparam logic [18:0] M_CSE     = 19'd1 << 7;
   localparam logic [18:0] M_GRA     = 19'd1 << 6;
   localparam logic [18:0] M_GRB     = 19'd1 << 5;
   localparam logic [18:0] M_GRC     = 19'd1 << 4;
   localparam logic [18:0] M_R_IN    = 19'd1 << 3;
   localparam logic [18:0] M_R_OUT   = 19'd1 << 2;
   localparam logic [18:0] M_BA_OUT  = 19'd1 << 1;
   localparam logic [18:0] M_R8_EN   = 19'd1 << 0;

   localparam logic [4:0] OP_LDI  = 5'b01001;
   localparam logic [4:0] OP_JAL  = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // Control set the requirements table lists for each state number.
   function automatic logic [18:0] sig_of(input int s);
      case (s)
         1:       return M_PC_OUT | M_MAR_EN | M_PC_INC | M_Z_EN;
         2:       return M_READ | M_MDR_EN | M_ZLO | M_PC_EN;
         3:       return M_MDR_OUT | M_IR_EN;
         4:       return M_GRB | M_BA_OUT | M_Y_EN;
         5:       return M_CSE | M_Z_EN;
         6, 12:   return M_ZLO | M_GRA | M_R_IN;
         7:       return M_PC_OUT | M_R8_EN;
         8, 9:    return M_GRA | M_R_OUT | M_PC_EN;
         10:      return M_GRB | M_R_OUT | M_Y_EN;
         11:      return M_GRC | M_R_OUT | M_Z_EN;
         default: return 19'd0;
      endcase
   endfunction

   // Execute-phase state list for an opcode; length equals the execute latency.
   function automatic int exec_len(input logic [4:0] op);
      case (op)
         OP_LDI:  return 3;
         OP_JAL:  return 2;
         OP_JR:   return 1;
         OP_ADD:  return 3;
         default: return 0;
      endcase
   endfunction

   function automatic int exec_first(input logic [4:0] op);
      case (op)
         OP_LDI:  return 4;
         OP_JAL:  return 7;
         OP_JR:   return 9;
         OP_ADD:  return 10;
         default: return 1;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction starting from an observed T0, checking every cycle
   // up to and including the following T0.
   task automatic exec_instr(input logic [4:0] op, input string tag);
      int exp_q[$];
      ir = {op, 27'($urandom)};
      exp_q.push_back(2);
      exp_q.push_back(3);
      for (int k = 0; k < exec_len(op); k++) exp_q.push_back(exec_first(op) + k);
      exp_q.push_back(1);
      for (int i = 0; i < exp_q.size(); i++) begin
         step();
         n_checks++;
         if (state !== 5'(exp_q[i]))
            $display("FAIL %s state[%0d]: got %0d want %0d", tag, i, state, exp_q[i]);
         else n_pass++;
         n_checks++;
         if (obs_sig !== sig_of(exp_q[i]))
            $display("FAIL %s ctrl[%0d]: got %05h want %05h", tag, i, obs_sig, sig_of(exp_q[i]));
         else n_pass++;
         n_checks++;
         if (run !== 1'b1)
            $display("FAIL %s run[%0d]: got %b want 1", tag, i, run);
         else n_pass++;
         n_checks++;
         if ($countones(drivers) > 1)
            $display("FAIL %s bus_drivers[%0d]: got %06b want at most one", tag, i, drivers);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      clr = 1'b1;
      ir  = $urandom;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (state !== 5'd0 || obs_sig !== 19'd0 || run !== 1'b0)
            $display("FAIL reset_hold[%0d]: got state %0d ctrl %05h run %b want 0 0 0",
                     i, state, obs_sig, run);
         else n_pass++;
      end
      clr = 1'b0;
      step();
      n_checks++;
      if (state !== 5'd1 || obs_sig !== sig_of(1) || run !== 1'b1)
         $display("FAIL reset_exit: got state %0d ctrl %05h run %b want 1 %05h 1",
                  state, obs_sig, run, sig_of(1));
      else n_pass++;
   endtask

   task automatic test_ldi();
      exec_instr(OP_LDI, "ldi");
   endtask

   task automatic test_jal();
      exec_instr(OP_JAL, "jal");
   endtask

   task automatic test_jr_add();
      exec_instr(OP_JR, "jr");
      exec_instr(OP_ADD, "add");
   endtask

   task automatic test_nop();
      exec_instr(5'b00000, "nop0");
      exec_instr(5'b11111, "nop1f");
   endtask

   task automatic test_back_to_back();
      exec_instr(OP_ADD, "b2b_add");
      exec_instr(OP_LDI, "b2b_ldi");
      exec_instr(OP_JR, "b2b_jr");
      exec_instr(5'b00001, "b2b_nop");
   endtask

   task automatic test_clr_mid_add();
      int seq[4] = '{2, 3, 10, 11};
      ir = {OP_ADD, 27'($urandom)};
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (state !== 5'(seq[i]))
            $display("FAIL clr_mid_add state[%0d]: got %0d want %0d", i, state, seq[i]);
         else n_pass++;
      end
      clr = 1'b1;
      step();
      n_checks++;
      if (state !== 5'd0 || obs_sig !== 19'd0 || run !== 1'b0)
         $display("FAIL clr_mid_add_rst: got state %0d ctrl %05h run %b want 0 0 0",
                  state, obs_sig, run);
      else n_pass++;
      clr = 1'b0;
      step();
      n_checks++;
      if (state !== 5'd1 || obs_sig !== sig_of(1))
         $display("FAIL clr_mid_add_restart: got state %0d ctrl %05h want 1 %05h",
                  state, obs_sig, sig_of(1));
      else n_pass++;
      exec_instr(OP_JAL, "post_clr_jal");
   endtask

   task automatic test_random();
      logic [4:0] op;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 4))
            0: op = OP_LDI;
            1: op = OP_JAL;
            2: op = OP_JR;
            3: op = OP_ADD;
            default: begin
               op = 5'($urandom);
               if (op == OP_HALT) op = 5'b00000;
            end
         endcase
         exec_instr(op, "random");
      end
   endtask

   task automatic test_halt();
      ir = {OP_HALT, 27'($urandom)};
      step();
      n_checks++;
      if (state !== 5'd2) $display("FAIL halt_t1: got %0d want 2", state);
      else n_pass++;
      step();
      n_checks++;
      if (state !== 5'd3) $display("FAIL halt_t2: got %0d want 3", state);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         step();
         ir = $urandom;
         n_checks++;
         if (state !== 5'd13 || run !== 1'b0 || obs_sig !== 19'd0)
            $display("FAIL halt_hold[%0d]: got state %0d run %b ctrl %05h want 13 0 0",
                     i, state, run, obs_sig);
         else n_pass++;
      end
      clr = 1'b1;
      step();
      n_checks++;
      if (state !== 5'd0 || obs_sig !== 19'd0 || run !== 1'b0)
         $display("FAIL halt_clr: got state %0d ctrl %05h run %b want 0 0 0", state, obs_sig, run);
      else n_pass++;
      clr = 1'b0;
      step();
      n_checks++;
      if (state !== 5'd1 || run !== 1'b1)
         $display("FAIL halt_restart: got state %0d run %b want 1 1", state, run);
      else n_pass++;
   endtask

   initial begin
      clr = 1'b1;
      ir  = 32'h0;
      test_reset();
      test_ldi();
      test_jal();
      test_jr_add();
      test_nop();
      test_back_to_back();
      test_clr_mid_add();
      test_random();
      test_halt();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
